// File: rtl/io_fifo_trigger_ctrl_if.sv
// io_fifo_trigger_ctrl_if: FIFO-side strobes and level seen by the trigger controller
// Signals:
//   elements  FIFO fill level (elements_o)
//   push      write accepted (valid_i & ready_o)
//   pop       read accepted (valid_o & ready_i)
//   wr_valid  write attempted (valid_i)
//   clr       FIFO clear (clr_i)
// Modports: master = FIFO side, slave = controller side.
interface io_fifo_trigger_ctrl_if #(
    parameter int LOG_BUFFER_DEPTH = 4
);
    logic [LOG_BUFFER_DEPTH:0] elements;
    logic                      push;
    logic                      pop;
    logic                      wr_valid;
    logic                      clr;
    modport master (output elements, push, pop, wr_valid, input clr);
    modport slave  (input elements, push, pop, wr_valid, output clr);
endinterface

// File: rtl/io_fifo_trigger_ctrl.sv
// io_fifo_trigger_ctrl: clear sequencer and 16550-style trigger/timeout irq for a UART RX FIFO
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   cfg_trig_lvl_i       trigger select: 1, DEPTH/4, DEPTH/2, DEPTH-2 elements
//   cfg_timeout_i        idle cycles before timeout irq, 0 disables
//   cfg_irq_en_i         [0] trigger irq enable, [1] timeout irq enable
//   cfg_clr_req_i        single-cycle clear request
//   fifo                 FIFO level/strobes in, FIFO clear out
//   clr_busy_o           clear sequence in progress
//   irq_trig_o           level at/above trigger
//   irq_timeout_o        sticky timeout status
//   irq_o                combined masked interrupt
//   overrun_o            sticky overrun flag
// Optional: define IO_FIFO_OVERRUN_DETECT_EN to enable overrun detection.
module io_fifo_trigger_ctrl #(
    parameter int LOG_BUFFER_DEPTH = 4,
    parameter int TIMEOUT_W        = 10
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [1:0]           cfg_trig_lvl_i,
    input  logic [TIMEOUT_W-1:0] cfg_timeout_i,
    input  logic [1:0]           cfg_irq_en_i,
    input  logic                 cfg_clr_req_i,
    io_fifo_trigger_ctrl_if.slave fifo,
    output logic                 clr_busy_o,
    output logic                 irq_trig_o,
    output logic                 irq_timeout_o,
    output logic                 irq_o,
    output logic                 overrun_o
);
    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_CLR    = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [LOG_BUFFER_DEPTH:0] DEPTH_L = {1'b1, {LOG_BUFFER_DEPTH{1'b0}}};
    localparam logic [LOG_BUFFER_DEPTH:0] TH_1    = (LOG_BUFFER_DEPTH+1)'(1);
    localparam logic [LOG_BUFFER_DEPTH:0] TH_F    = DEPTH_L - (LOG_BUFFER_DEPTH+1)'(2);

    logic [1:0]                state, state_n;
    logic                      clr_q;
    logic [TIMEOUT_W-1:0]      cnt;
    logic [LOG_BUFFER_DEPTH:0] thr;
    logic                      run, empty, cnt_clr, tmo_set, tmo_clr;

    assign run     = state == S_RUN;
    assign empty   = fifo.elements == '0;
    assign state_n = run ? (cfg_clr_req_i ? S_CLR : S_RUN) : (state == S_CLR ? S_SETTLE : S_RUN);
    assign thr     = cfg_trig_lvl_i == 2'd0 ? TH_1 :
                     cfg_trig_lvl_i == 2'd1 ? DEPTH_L >> 2 :
                     cfg_trig_lvl_i == 2'd2 ? DEPTH_L >> 1 : TH_F;
    assign cnt_clr = fifo.push | fifo.pop | empty | ~|cfg_timeout_i | ~run;
    assign tmo_set = (cnt == cfg_timeout_i) & |cfg_timeout_i;
    // Leaving RUN (CLR/SETTLE) clears every status flag, so clear wins over set.
    assign tmo_clr = fifo.pop | empty | ~run;

    assign fifo.clr   = clr_q;
    assign clr_busy_o = ~run;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= S_RUN;
            clr_q         <= 1'b0;
            cnt           <= '0;
            irq_trig_o    <= 1'b0;
            irq_timeout_o <= 1'b0;
        end else begin
            state         <= state_n;
            clr_q         <= state_n == S_CLR;
            // Saturating increment: adds 0 once all-ones is reached.
            cnt           <= cnt_clr ? '0 : cnt + TIMEOUT_W'(~&cnt);
            irq_trig_o    <= run & (fifo.elements >= thr);
            irq_timeout_o <= tmo_clr ? 1'b0 : (irq_timeout_o | tmo_set);
        end
    end

`ifdef IO_FIFO_OVERRUN_DETECT_EN
    logic ovr_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) ovr_q <= 1'b0;
        else         ovr_q <= run & (ovr_q | (fifo.wr_valid & (fifo.elements == DEPTH_L)));
    end
    assign overrun_o = ovr_q;
    assign irq_o     = (irq_trig_o & cfg_irq_en_i[0]) | (irq_timeout_o & cfg_irq_en_i[1]) | ovr_q;
`else
    logic unused_wr_valid;
    assign unused_wr_valid = fifo.wr_valid;
    assign overrun_o       = 1'b0;
    assign irq_o           = (irq_trig_o & cfg_irq_en_i[0]) | (irq_timeout_o & cfg_irq_en_i[1]);
`endif
endmodule

// File: tb/tb_io_fifo_trigger_ctrl.sv
// tb_io_fifo_trigger_ctrl: self-checking bench for io_fifo_trigger_ctrl
module tb_io_fifo_trigger_ctrl;
    localparam int LB   = 4;
    localparam int TW   = 10;
    localparam int D    = 16;
    localparam int CMAX = 1023;
`ifdef IO_FIFO_OVERRUN_DETECT_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [1:0]    trig_lvl = 2'd2;
    logic [TW-1:0] tmo_cfg = '0;
    logic [1:0]    irq_en = 2'd3;
    logic          req = 1'b0;
    logic          clr_busy, irq_trig, irq_tmo, irq, ovr;
    int            total = 0;
    int            bad = 0;
    int            lvl = 0;
    bit            chk_on = 1'b0;

    io_fifo_trigger_ctrl_if #(.LOG_BUFFER_DEPTH(LB)) fif ();

    io_fifo_trigger_ctrl #(.LOG_BUFFER_DEPTH(LB), .TIMEOUT_W(TW)) dut (
        .clk_i(clk), .rstn_i(rstn), .cfg_trig_lvl_i(trig_lvl), .cfg_timeout_i(tmo_cfg),
        .cfg_irq_en_i(irq_en), .cfg_clr_req_i(req), .fifo(fif), .clr_busy_o(clr_busy),
        .irq_trig_o(irq_trig), .irq_timeout_o(irq_tmo), .irq_o(irq), .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: busy countdown (2 = clearing, 1 = settling), idle run length,
    // and the three status flags recomputed from the rules at every clock.
    int m_busy_left = 0;
    int m_idle = 0;
    bit m_trig = 0, m_tmo = 0, m_ovr = 0;
    bit m_run, m_empty, m_hit;

    function automatic int thr(input logic [1:0] s);
        return s == 2'd0 ? 1 : s == 2'd1 ? D / 4 : s == 2'd2 ? D / 2 : D - 2;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy_left = 0; m_idle = 0; m_trig = 0; m_tmo = 0; m_ovr = 0;
        end else begin
            m_run   = m_busy_left == 0;
            m_empty = int'(fif.elements) == 0;
            m_hit   = tmo_cfg != 0 && m_idle == int'(tmo_cfg);
            m_trig  = m_run && int'(fif.elements) >= thr(trig_lvl);
            m_tmo   = (!m_run || fif.pop || m_empty) ? 1'b0 : (m_tmo || m_hit);
            m_ovr   = OVR && m_run && (m_ovr || (fif.wr_valid && int'(fif.elements) == D));
            if (!m_run || fif.push || fif.pop || m_empty || tmo_cfg == 0) m_idle = 0;
            else if (m_idle < CMAX) m_idle++;
            if (m_busy_left > 0) m_busy_left--;
            else if (req) m_busy_left = 2;
        end
    end

    always @(negedge clk) begin
        if (rstn && chk_on) begin
            chk("m_clr", fif.clr, m_busy_left == 2);
            chk("m_busy", clr_busy, m_busy_left > 0);
            chk("m_trig", irq_trig, m_trig);
            chk("m_tmo", irq_tmo, m_tmo);
            chk("m_ovr", ovr, m_ovr);
            chk("m_irq", irq, (m_trig & irq_en[0]) | (m_tmo & irq_en[1]) | m_ovr);
        end
    end

    task automatic cyc(input bit p, input bit q, input bit w, input bit r);
        fif.push = p; fif.pop = q; fif.wr_valid = w; req = r;
        @(posedge clk); #2;
        lvl = lvl + int'(p) - int'(q);
        fif.elements = (LB+1)'(lvl);
        fif.push = 0; fif.pop = 0; fif.wr_valid = 0; req = 0;
    endtask

    task automatic set_lvl(input int n);
        lvl = n;
        fif.elements = (LB+1)'(n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fif.elements = '0; fif.push = 0; fif.pop = 0; fif.wr_valid = 0;
        #1 rstn = 0;
        #1;
        chk("rst_clr", fif.clr, 0); chk("rst_busy", clr_busy, 0); chk("rst_trig", irq_trig, 0);
        chk("rst_tmo", irq_tmo, 0); chk("rst_irq", irq, 0); chk("rst_ovr", ovr, 0);
        @(posedge clk); #2 rstn = 1;
        chk_on = 1;
        // trigger level DEPTH/2
        repeat (7) cyc(1, 0, 0, 0);
        chk("trig_at7", irq_trig, 0);
        cyc(1, 0, 0, 0);
        chk("trig_lag", irq_trig, 0);
        cyc(0, 0, 0, 0);
        chk("trig_at8", irq_trig, 1);
        chk("irq_at8", irq, 1);
        cyc(0, 1, 0, 0);
        chk("trig_pop_lag", irq_trig, 1);
        cyc(0, 0, 0, 0);
        chk("trig_at7b", irq_trig, 0);
        trig_lvl = 2'd3; cyc(0, 0, 0, 0); chk("trig_l3", irq_trig, 0);
        trig_lvl = 2'd1; cyc(0, 0, 0, 0); chk("trig_l1", irq_trig, 1);
        trig_lvl = 2'd2; cyc(0, 0, 0, 0); chk("trig_l2", irq_trig, 0);
        // timeout
        tmo_cfg = 10'd5;
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        chk("tmo_5", irq_tmo, 0);
        cyc(0, 0, 0, 0);
        chk("tmo_6", irq_tmo, 1);
        cyc(1, 0, 0, 0);
        chk("tmo_push", irq_tmo, 1);
        cyc(0, 1, 0, 0);
        chk("tmo_pop", irq_tmo, 0);
        // clear sequence at level 10
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        chk("pre_trig", irq_trig, 1);
        chk("pre_tmo", irq_tmo, 1);
        cyc(0, 0, 0, 1);
        chk("clr_1", fif.clr, 1); chk("busy_1", clr_busy, 1);
        cyc(0, 0, 0, 1);
        set_lvl(0);
        chk("clr_2", fif.clr, 0); chk("busy_2", clr_busy, 1);
        chk("settle_trig", irq_trig, 0); chk("settle_tmo", irq_tmo, 0); chk("settle_irq", irq, 0);
        cyc(0, 0, 0, 0);
        chk("clr_3", fif.clr, 0); chk("busy_3", clr_busy, 0);
        cyc(0, 0, 0, 0);
        chk("clr_4", fif.clr, 0);
        // timeout disabled, masking
        tmo_cfg = '0;
        cyc(1, 0, 0, 0);
        repeat (2000) cyc(0, 0, 0, 0);
        chk("tmo_off", irq_tmo, 0);
        trig_lvl = 2'd0;
        cyc(0, 0, 0, 0);
        chk("trig_l0", irq_trig, 1);
        irq_en = 2'd0; #1 chk("irq_mask", irq, 0);
        irq_en = 2'd1; #1 chk("irq_unmask", irq, 1);
        irq_en = 2'd3;
        // reset during CLR
        cyc(0, 0, 0, 1);
        chk("clr_pre_rst", fif.clr, 1);
        #1 rstn = 0;
        #1;
        chk("arst_clr", fif.clr, 0); chk("arst_busy", clr_busy, 0);
        chk("arst_trig", irq_trig, 0); chk("arst_irq", irq, 0);
        @(posedge clk); #2 rstn = 1;
        tmo_cfg = 10'd3;
        repeat (3) cyc(0, 0, 0, 0);
        chk("post_rst_busy", clr_busy, 0);
        chk("post_rst_tmo3", irq_tmo, 0);
        cyc(0, 0, 0, 0);
        chk("post_rst_tmo4", irq_tmo, 1);
        // overrun
        tmo_cfg = '0;
        set_lvl(D);
        irq_en = 2'd0;
        cyc(0, 0, 1, 0);
        chk("ovr_set", ovr, OVR);
        chk("ovr_irq", irq, OVR);
        repeat (3) cyc(0, 0, 0, 0);
        chk("ovr_hold", ovr, OVR);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("ovr_cleared", ovr, 0);
        irq_en = 2'd3;
        repeat (3) cyc(0, 0, 0, 0);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
